// File: rtl/data_island_packet_serializer.sv
// HDMI data-island packet serializer: captures header + 4 subpackets at slot 0, appends BCH parity,
// and emits one 9-bit slice per pixel clock over 32 slots with a single register stage.
module data_island_packet_serializer (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [8:0]       packet_data,
    output logic             packet_valid,
    output logic             packet_last,
    output logic             packet_abort
);

    logic [4:0]       slot;
    logic [23:0]      hdr_q;
    logic [3:0][55:0] sub_q;
    logic [7:0]       ecc_h_q;
    logic [3:0][7:0]  ecc_s_q;

    logic [23:0]      hdr_w;
    logic [3:0][55:0] sub_w;
    logic [7:0]       ecc_h_cur;
    logic [7:0]       ecc_h_nxt;
    logic [3:0][7:0]  ecc_s_cur;
    logic [3:0][7:0]  ecc_s_mid;
    logic [3:0][7:0]  ecc_s_nxt;
    logic [8:0]       slice;

    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
    endfunction

    // Slot 0 is served straight from the inputs so the 1-cycle latency holds; ECC restarts from 0 there.
    always_comb begin
        hdr_w     = (slot == 5'd0) ? header : hdr_q;
        sub_w     = (slot == 5'd0) ? sub    : sub_q;
        ecc_h_cur = (slot == 5'd0) ? 8'h00  : ecc_h_q;
        ecc_s_cur = (slot == 5'd0) ? '0     : ecc_s_q;
        ecc_h_nxt = ecc_h_cur;
        ecc_s_mid = ecc_s_cur;
        ecc_s_nxt = ecc_s_cur;
        slice     = '0;

        if (slot < 5'd24) begin
            ecc_h_nxt = bch_step(ecc_h_cur, hdr_w[slot]);
            slice[0]  = hdr_w[slot];
        end else begin
            slice[0]  = ecc_h_q[slot[2:0]];
        end

        for (int i = 0; i < 4; i++) begin
            if (slot < 5'd28) begin
                ecc_s_mid[i] = bch_step(ecc_s_cur[i], sub_w[i][{slot, 1'b0}]);
                ecc_s_nxt[i] = bch_step(ecc_s_mid[i], sub_w[i][{slot, 1'b1}]);
                slice[1+i]   = sub_w[i][{slot, 1'b0}];
                slice[5+i]   = sub_w[i][{slot, 1'b1}];
            end else begin
                // Parity registers are final here: the last data update happened in slot 27.
                slice[1+i]   = ecc_s_q[i][{slot[1:0], 1'b0}];
                slice[5+i]   = ecc_s_q[i][{slot[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            slot         <= '0;
            hdr_q        <= '0;
            sub_q        <= '0;
            ecc_h_q      <= '0;
            ecc_s_q      <= '0;
            packet_data  <= '0;
            packet_valid <= 1'b0;
            packet_last  <= 1'b0;
            packet_abort <= 1'b0;
        end else begin
            packet_valid <= data_island_period;
            packet_last  <= data_island_period && (slot == 5'd31);
            packet_abort <= !data_island_period && (slot != 5'd0);
            packet_data  <= data_island_period ? slice : 9'd0;
            if (data_island_period) begin
                slot    <= slot + 5'd1;
                ecc_h_q <= ecc_h_nxt;
                ecc_s_q <= ecc_s_nxt;
                if (slot == 5'd0) begin
                    hdr_q <= header;
                    sub_q <= sub;
                end
            end else begin
                slot    <= '0;
                ecc_h_q <= '0;
                ecc_s_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Bench for data_island_packet_serializer: whole-packet codeword model, random packets,
// input scrambling after slot 0, abort and mid-packet reset.
module tb_data_island_packet_serializer;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             data_island_period;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [8:0]       packet_data;
    logic             packet_valid;
    logic             packet_last;
    logic             packet_abort;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] obs_h;
    logic        obs_sub_any;

    always #5 clk_pixel = ~clk_pixel;

    data_island_packet_serializer dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .packet_data        (packet_data),
        .packet_valid       (packet_valid),
        .packet_last        (packet_last),
        .packet_abort       (packet_abort)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Parity of the first n bits of d, fed LSB first through x^8+x^7+x^6+1.
    function automatic logic [7:0] bch(input logic [63:0] d, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int k = 0; k < n; k++)
            e = (e >> 1) ^ (((e[0] ^ d[k]) == 1'b1) ? 8'h83 : 8'h00);
        return e;
    endfunction

    function automatic logic [55:0] rand56();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[55:0];
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic rand_pkt(output logic [23:0] h, output logic [3:0][55:0] s);
        h = 24'($urandom);
        for (int i = 0; i < 4; i++) s[i] = rand56();
    endtask

    // Drives n slots of a packet; scramble=1 changes the inputs on every slot after slot 0.
    task automatic send_packet(input logic [23:0] h, input logic [3:0][55:0] s,
                               input bit scramble, input int n);
        logic [31:0]      hc;
        logic [3:0][63:0] sc;
        logic [8:0]       exp;
        hc = {bch({40'd0, h}, 24), h};
        for (int i = 0; i < 4; i++) sc[i] = {bch({8'd0, s[i]}, 56), s[i]};
        obs_sub_any = 1'b0;
        for (int c = 0; c < n; c++) begin
            data_island_period = 1'b1;
            if (c == 0 || !scramble) begin
                header = h;
                sub    = s;
            end else begin
                header = 24'($urandom);
                for (int i = 0; i < 4; i++) sub[i] = rand56();
            end
            tick();
            exp[0] = hc[c];
            for (int i = 0; i < 4; i++) begin
                exp[1+i] = sc[i][2*c];
                exp[5+i] = sc[i][2*c+1];
            end
            chk("data",  {55'd0, packet_data}, {55'd0, exp});
            chk("valid", {63'd0, packet_valid}, 64'd1);
            chk("last",  {63'd0, packet_last},  {63'd0, (c == 31)});
            chk("abort", {63'd0, packet_abort}, 64'd0);
            obs_h[c]    = packet_data[0];
            obs_sub_any = obs_sub_any | (|packet_data[8:1]);
        end
    endtask

    task automatic idle(input bit exp_abort);
        data_island_period = 1'b0;
        header = 24'($urandom);
        tick();
        chk("idle_data",  {55'd0, packet_data}, 64'd0);
        chk("idle_valid", {63'd0, packet_valid}, 64'd0);
        chk("idle_last",  {63'd0, packet_last},  64'd0);
        chk("idle_abort", {63'd0, packet_abort}, {63'd0, exp_abort});
    endtask

    initial begin
        logic [23:0]      h;
        logic [3:0][55:0] s;

        reset = 1'b1;
        data_island_period = 1'b1;
        header = 24'hABCDEF;
        for (int i = 0; i < 4; i++) sub[i] = rand56();
        tick();
        tick();
        chk("rst_data",  {55'd0, packet_data}, 64'd0);
        chk("rst_valid", {63'd0, packet_valid}, 64'd0);
        chk("rst_last",  {63'd0, packet_last},  64'd0);
        chk("rst_abort", {63'd0, packet_abort}, 64'd0);
        reset = 1'b0;
        idle(1'b0);

        // zero packet
        send_packet(24'd0, '0, 1'b0, 32);
        idle(1'b0);

        // single header bit: known parity 8'h4A
        send_packet(24'h000001, '0, 1'b0, 32);
        chk("hdr_bits", {40'd0, obs_h[23:0]}, 64'h1);
        chk("hdr_ecc",  {56'd0, obs_h[31:24]}, 64'h4A);
        chk("sub_zero", {63'd0, obs_sub_any}, 64'd0);
        idle(1'b0);

        // back-to-back random packets
        for (int p = 0; p < 1000; p++) begin
            rand_pkt(h, s);
            send_packet(h, s, 1'b0, 32);
        end
        idle(1'b0);

        // inputs changing every cycle after slot 0
        for (int p = 0; p < 8; p++) begin
            rand_pkt(h, s);
            send_packet(h, s, 1'b1, 32);
        end
        idle(1'b0);

        // abort after slot 10
        rand_pkt(h, s);
        send_packet(h, s, 1'b0, 11);
        idle(1'b1);
        idle(1'b0);
        rand_pkt(h, s);
        send_packet(h, s, 1'b0, 32);
        idle(1'b0);

        // reset at slot 17, reset wins over data_island_period
        rand_pkt(h, s);
        send_packet(h, s, 1'b0, 17);
        reset = 1'b1;
        data_island_period = 1'b1;
        tick();
        chk("mrst_data",  {55'd0, packet_data}, 64'd0);
        chk("mrst_valid", {63'd0, packet_valid}, 64'd0);
        chk("mrst_last",  {63'd0, packet_last},  64'd0);
        chk("mrst_abort", {63'd0, packet_abort}, 64'd0);
        reset = 1'b0;
        idle(1'b0);
        rand_pkt(h, s);
        send_packet(h, s, 1'b0, 32);
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
